lzc_seq_ctrl: RTL



---
 rtl/lzc_seq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lzc_seq_ctrl.sv
// lzc_seq_ctrl -- multi-cycle leading-zero counter for a NUM_BYTES*8-bit word.
// One 8-bit leading-zero evaluation is reused each cycle, scanning the
// captured word MSB byte first and accumulating the count.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   data_in/in_valid/in_ready      word input handshake (accepted only in IDLE)
//   data_out/all_zero/out_valid/out_ready  result handshake (held in DONE)
//   busy               block is not IDLE
module lzc_seq_ctrl #(
    parameter int NUM_BYTES  = 4,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CNT_W      = $clog2(8*NUM_BYTES+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] data_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CNT_W-1:0]       data_out,
    output logic                   all_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int W     = 8*NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     word_q;
    logic [IDX_W-1:0] idx;
    logic             found;      // result already latched (matters for fixed-latency scans)

    logic [W-1:0]     shifted;
    logic [7:0]       slice;
    logic [3:0]       lz;
    logic             nz;
    logic             last;
    logic             scan_end;
    logic [CNT_W-1:0] pos;

    // Leading zeros of one byte: 0..7, or 8 for a zero byte.
    function automatic logic [3:0] lz8(input logic [7:0] b);
        lz8 = 4'd8;
        for (int i = 0; i < 8; i++)
            if (b[i]) lz8 = 4'(7 - i);   // highest set bit wins (last write)
    endfunction

    // Bring slice idx to the top byte so slice 0 is the MSB byte.
    always_comb begin
        shifted  = word_q << {idx, 3'b000};
        slice    = shifted[W-1 -: 8];
        lz       = lz8(slice);
        nz       = |slice;
        last     = (idx == IDX_W'(NUM_BYTES-1));
        scan_end = last || (EARLY_EXIT && nz);
        pos      = (CNT_W'(idx) << 3) + CNT_W'(lz);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SCAN;
            SCAN:    if (scan_end)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs; in_ready is masked by rst so a word offered during reset is not implied accepted.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: capture, scan index, count accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            idx      <= '0;
            data_out <= '0;
            all_zero <= 1'b0;
            found    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    word_q   <= data_in;
                    idx      <= '0;
                    data_out <= '0;
                    all_zero <= 1'b0;
                    found    <= 1'b0;
                end
                SCAN: begin
                    // First non-zero slice fixes the result; later slices are ignored.
                    if (!found && nz) begin
                        data_out <= pos;
                        found    <= 1'b1;
                    end else if (!found && last) begin
                        data_out <= CNT_W'(W);
                        all_zero <= 1'b1;
                    end
                    if (!scan_end) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
